rgb_to_yuv_converter: RTL and testbench
=======================================

# rgb_to_yuv_converter

- Frame-level RGB→YUV (BT.601, studio range) converter, the inverse of the YUV→RGB colour conversion path.
- Reads three planar 8-bit RGB planes from the shared 16-bit frame memory and writes three planar Y/U/V planes back to the same memory.
- Each memory word holds two pixels: even pixel in [7:0], odd pixel in [15:8].
- Runs one full frame per `start` pulse under its own FSM and signals completion with `done`.

## Interface
Parameters:
- PIXEL_WORDS, 38400, words per plane (320×240 pixels / 2)
- OUT_BASE, 115200, first write address of the Y plane
- CYR, 16829 / CYG, 33039 / CYB, 6416, Y coefficients, Q16 signed, 18-bit
- CUR, -9714 / CUG, -19070 / CUB, 28784, U coefficients, Q16 signed, 18-bit
- CVR, 28784 / CVG, -24103 / CVB, -4681, V coefficients, Q16 signed, 18-bit
- Y_OFF, 16 / C_OFF, 128, output offsets

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one frame conversion; sampled only in IDLE
- R_addr  out  18  memory read address
- R_en  out  1  read strobe; R_data valid the cycle after
- R_data  in  16  memory read data
- W_addr  out  18  memory write address
- W_en  out  1  write strobe
- W_data  out  16  write data {odd result, even result}
- busy  out  1  high whenever FSM is not IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- Word index `idx` (16-bit) runs from 0 to PIXEL_WORDS-1.
- Read addresses:
  - R at idx
  - G at PIXEL_WORDS+idx
  - B at 2·PIXEL_WORDS+idx
- Write addresses:
  - Y at OUT_BASE+idx
  - U at OUT_BASE+PIXEL_WORDS+idx
  - V at OUT_BASE+2·PIXEL_WORDS+idx
- FSM states:
  - IDLE: start=1 → RD_R, idx←0.
  - RD_R: R_en=1, R address.
  - RD_G: capture R word; R_en=1, G address.
  - RD_B: capture G word; R_en=1, B address.
  - CAP_B: capture B word.
  - WR_Y: W_en=1 with Y result.
  - WR_U: W_en=1 with U result.
  - WR_V: W_en=1 with V result. If idx==PIXEL_WORDS-1 → DONE; else idx+1 → RD_R.
  - DONE: done=1 → IDLE.
- Arithmetic, per pixel lane (even and odd computed in parallel):
  - Inputs R, G, B are zero-extended to 9-bit signed.
  - s = C_R·R + C_G·G + C_B·B + 32768, as a 32-bit signed sum.
  - r = (s >>> 16) + offset, using an arithmetic shift (floor).
  - Clamp r to [0,255].
- `start` while busy is ignored. `start` held high in IDLE after DONE starts a new frame.
- Captured registers, `idx` and state are cleared only by reset. They are never cleared on start, except that `idx` is set to 0 on start.

## Timing
- Reset (rst=0, async) values:
  - state IDLE, idx 0
  - all captured words 0
  - R_en, W_en, busy, done = 0
  - R_addr, W_addr, W_data = 0
- Reset mid-frame aborts immediately. No further writes occur, done does not pulse, and the next frame requires a new start.
- Start sampled at edge t → RD_R during cycle t+1.
- 7 cycles per word. The first write (WR_Y, idx 0) occurs at cycle t+5.
- Last WR_V at cycle t+7·PIXEL_WORDS. done is high for cycle t+7·PIXEL_WORDS+1. busy drops the following cycle.
- Memory is assumed to have exactly 1-cycle read latency. R_en and W_en are never high in the same cycle.
- W_data and W_addr are registered-stable for the whole cycle W_en=1. W_data is 0 when W_en=0.

## Test plan
- Black: all R, G, B words 0x0000, PIXEL_WORDS=4 → every Y word 0x1010, every U/V word 0x8080; done at start+29.
- White: all words 0xFFFF → Y 0xEBEB, U 0x8080, V 0x8080.
- Lane independence: R=0x00FF, G=B=0 → Y 0x1051, U 0x805A, V 0x80F0. This covers red in the even lane and black in the odd lane, with floor rounding on negative U.
- Clamp: instance with CYR=65535, R=0xFFFF, G=B=0 → Y 0xFFFF (271 clamped to 255). Repeat with Y_OFF=0 and CYR=-65535 → Y 0x0000.
- Handshake: start pulsed again mid-frame → ignored, write count stays 3·PIXEL_WORDS. Start held high → second frame begins the cycle after done.
- Reset asserted at WR_U of idx 1 → outputs 0 asynchronously, no WR_V, no done. A fresh start then produces a complete, correct frame.

Source files
------------

// File: rtl/rgb_to_yuv_if.sv
// Frame-memory and control bundle for the RGB->YUV converter.
// The converter takes the master side; the memory/controller side takes the slave side.
interface rgb_to_yuv_if;
  logic        start;
  logic [17:0] R_addr;
  logic        R_en;
  logic [15:0] R_data;
  logic [17:0] W_addr;
  logic        W_en;
  logic [15:0] W_data;
  logic        busy;
  logic        done;

  modport master (
    input  start, R_data,
    output R_addr, R_en, W_addr, W_en, W_data, busy, done
  );

  modport slave (
    output start, R_data,
    input  R_addr, R_en, W_addr, W_en, W_data, busy, done
  );
endinterface

// File: rtl/rgb_to_yuv_converter.sv
// Frame-level BT.601 studio-range RGB->YUV converter over a shared 16-bit frame memory.
// Each word carries two pixels, and both lanes are converted in parallel. The converter takes 7 cycles per word.
module rgb_to_yuv_converter #(
  parameter int                PIXEL_WORDS = 38400,
  parameter int                OUT_BASE    = 115200,
  parameter logic signed [17:0] CYR = 18'sd16829,
  parameter logic signed [17:0] CYG = 18'sd33039,
  parameter logic signed [17:0] CYB = 18'sd6416,
  parameter logic signed [17:0] CUR = -18'sd9714,
  parameter logic signed [17:0] CUG = -18'sd19070,
  parameter logic signed [17:0] CUB = 18'sd28784,
  parameter logic signed [17:0] CVR = 18'sd28784,
  parameter logic signed [17:0] CVG = -18'sd24103,
  parameter logic signed [17:0] CVB = -18'sd4681,
  parameter int                Y_OFF = 16,
  parameter int                C_OFF = 128
) (
  input  logic          clk,
  input  logic          rst,
  rgb_to_yuv_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, RD_R, RD_G, RD_B, CAP_B, WR_Y, WR_U, WR_V, DONE
  } state_t;

  localparam logic [17:0] G_BASE   = 18'(PIXEL_WORDS);
  localparam logic [17:0] B_BASE   = 18'(2 * PIXEL_WORDS);
  localparam logic [17:0] Y_BASE   = 18'(OUT_BASE);
  localparam logic [17:0] U_BASE   = 18'(OUT_BASE + PIXEL_WORDS);
  localparam logic [17:0] V_BASE   = 18'(OUT_BASE + 2 * PIXEL_WORDS);
  localparam logic [15:0] LAST_IDX = 16'(PIXEL_WORDS - 1);
  localparam logic signed [31:0] Y_OFF_S = 32'(Y_OFF);
  localparam logic signed [31:0] C_OFF_S = 32'(C_OFF);

  state_t      state, state_next;
  logic [15:0] idx;
  logic [15:0] r_word, g_word, b_word;
  logic [17:0] idx_ext;
  logic        last_word;

  logic signed [17:0] coef_r, coef_g, coef_b;
  logic signed [31:0] coef_off;
  logic [15:0]        result;

  assign idx_ext   = {2'b00, idx};
  assign last_word = (idx == LAST_IDX);

  // One lane: Q16 dot product, round-half-up via +0.5 then floor shift, offset, clamp.
  function automatic logic [7:0] lane_convert(
    input logic [7:0]         r, g, b,
    input logic signed [17:0] cr, cg, cb,
    input logic signed [31:0] off
  );
    logic signed [31:0] s;
    logic signed [31:0] q;
    s = 32'(cr) * $signed({24'd0, r})
      + 32'(cg) * $signed({24'd0, g})
      + 32'(cb) * $signed({24'd0, b})
      + 32'sd32768;
    q = (s >>> 16) + off;
    if (q < 0)
      return 8'd0;
    else if (q > 255)
      return 8'd255;
    else
      return q[7:0];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Word index and captured input words. These are plain registers, not a memory, so they are reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      r_word <= '0;
      g_word <= '0;
      b_word <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.start) idx <= '0;
        RD_G:    r_word <= bus.R_data;
        RD_B:    g_word <= bus.R_data;
        CAP_B:   b_word <= bus.R_data;
        WR_V:    if (!last_word) idx <= idx + 16'd1;
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RD_R;
      RD_R:    state_next = RD_G;
      RD_G:    state_next = RD_B;
      RD_B:    state_next = CAP_B;
      CAP_B:   state_next = WR_Y;
      WR_Y:    state_next = WR_U;
      WR_U:    state_next = WR_V;
      WR_V:    state_next = last_word ? DONE : RD_R;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shared pair of lane datapaths; the write state selects the coefficient set.
  always_comb begin
    coef_r   = CYR;
    coef_g   = CYG;
    coef_b   = CYB;
    coef_off = Y_OFF_S;
    case (state)
      WR_U: begin
        coef_r   = CUR;
        coef_g   = CUG;
        coef_b   = CUB;
        coef_off = C_OFF_S;
      end
      WR_V: begin
        coef_r   = CVR;
        coef_g   = CVG;
        coef_b   = CVB;
        coef_off = C_OFF_S;
      end
      default: ;
    endcase
  end

  assign result = {
    lane_convert(r_word[15:8], g_word[15:8], b_word[15:8], coef_r, coef_g, coef_b, coef_off),
    lane_convert(r_word[7:0],  g_word[7:0],  b_word[7:0],  coef_r, coef_g, coef_b, coef_off)
  };

  // Outputs decode from registered state only, so they hold steady through each cycle.
  always_comb begin
    // NOTE: every output gets a default before the case; this keeps the block free of latches.
    bus.R_en   = 1'b0;
    bus.R_addr = '0;
    bus.W_en   = 1'b0;
    bus.W_addr = '0;
    bus.W_data = '0;
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    case (state)
      RD_R: begin
        bus.R_en   = 1'b1;
        bus.R_addr = idx_ext;
      end
      RD_G: begin
        bus.R_en   = 1'b1;
        bus.R_addr = G_BASE + idx_ext;
      end
      RD_B: begin
        bus.R_en   = 1'b1;
        bus.R_addr = B_BASE + idx_ext;
      end
      WR_Y: begin
        bus.W_en   = 1'b1;
        bus.W_addr = Y_BASE + idx_ext;
        bus.W_data = result;
      end
      WR_U: begin
        bus.W_en   = 1'b1;
        bus.W_addr = U_BASE + idx_ext;
        bus.W_data = result;
      end
      WR_V: begin
        bus.W_en   = 1'b1;
        bus.W_addr = V_BASE + idx_ext;
        bus.W_data = result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// Self-checking bench for rgb_to_yuv_converter: directed colour frames, random frames
// against a real-arithmetic BT.601 model, handshake and mid-frame reset, and clamp instances.
module tb_rgb_to_yuv_converter;

  localparam int N  = 4;
  localparam int OB = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb_to_yuv_if bus ();
  rgb_to_yuv_if if_hi ();
  rgb_to_yuv_if if_lo ();

  rgb_to_yuv_converter #(.PIXEL_WORDS(N), .OUT_BASE(OB)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  rgb_to_yuv_converter #(.PIXEL_WORDS(1), .OUT_BASE(3), .CYR(18'sd65535)) u_clamp_hi (
    .clk (clk), .rst (rst), .bus (if_hi)
  );
  rgb_to_yuv_converter #(.PIXEL_WORDS(1), .OUT_BASE(3), .CYR(-18'sd65535), .Y_OFF(0)) u_clamp_lo (
    .clk (clk), .rst (rst), .bus (if_lo)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] in_mem  [64];
  logic [15:0] out_mem [64];
  logic        clr = 1'b0;
  int          wr_count = 0;
  int          overlap_count = 0;
  int          idle_wdata_count = 0;
  logic [15:0] y_hi = 16'h1234;
  logic [15:0] y_lo = 16'h1234;

  // Frame memory with exactly one cycle of read latency.
  always @(posedge clk) begin
    if (bus.R_en) bus.R_data <= in_mem[bus.R_addr[5:0]];
    if (bus.R_en && bus.W_en) overlap_count <= overlap_count + 1;
    if (!bus.W_en && bus.W_data != 16'h0) idle_wdata_count <= idle_wdata_count + 1;
    if (clr) begin
      for (int i = 0; i < 64; i++) out_mem[i] <= 16'h0;
      wr_count <= 0;
    end else if (bus.W_en) begin
      out_mem[bus.W_addr[5:0]] <= bus.W_data;
      wr_count <= wr_count + 1;
    end
  end

  // Clamp instances: R plane is word 0 (all ones), G and B read as zero; Y lands at address 3.
  always @(posedge clk) begin
    if (if_hi.R_en) if_hi.R_data <= (if_hi.R_addr == 18'd0) ? 16'hFFFF : 16'h0000;
    if (if_lo.R_en) if_lo.R_data <= (if_lo.R_addr == 18'd0) ? 16'hFFFF : 16'h0000;
    if (if_hi.W_en && if_hi.W_addr == 18'd3) y_hi <= if_hi.W_data;
    if (if_lo.W_en && if_lo.W_addr == 18'd3) y_lo <= if_lo.W_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // BT.601 studio-range reference: real-valued dot product, round half up, offset, clip.
  function automatic logic [7:0] ref_lane(input int kind, input int r, input int g, input int b);
    real cr, cg, cb, off, y;
    int  v;
    case (kind)
      0:       begin cr = 16829.0; cg = 33039.0;  cb = 6416.0;  off = 16.0;  end
      1:       begin cr = -9714.0; cg = -19070.0; cb = 28784.0; off = 128.0; end
      default: begin cr = 28784.0; cg = -24103.0; cb = -4681.0; off = 128.0; end
    endcase
    y = $floor((cr * r + cg * g + cb * b) / 65536.0 + 0.5) + off;
    v = int'(y);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  function automatic logic [15:0] ref_word(input int kind, input logic [15:0] rw,
                                           input logic [15:0] gw, input logic [15:0] bw);
    return {ref_lane(kind, int'(rw[15:8]), int'(gw[15:8]), int'(bw[15:8])),
            ref_lane(kind, int'(rw[7:0]),  int'(gw[7:0]),  int'(bw[7:0]))};
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < 3 * N; i++) begin
      case (mode)
        0:       in_mem[i] = 16'h0000;
        1:       in_mem[i] = 16'hFFFF;
        2:       in_mem[i] = (i < N) ? 16'h00FF : 16'h0000;
        default: in_mem[i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic clear_out();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic verify_model(input string tag);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++)
        check($sformatf("%s_plane%0d_w%0d", tag, k, i), 32'(out_mem[OB + k * N + i]),
              32'(ref_word(k, in_mem[i], in_mem[N + i], in_mem[2 * N + i])));
  endtask

  task automatic verify_const(input string tag, input logic [15:0] y, input logic [15:0] u,
                              input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_y%0d", tag, i), 32'(out_mem[OB + i]), 32'(y));
      check($sformatf("%s_u%0d", tag, i), 32'(out_mem[OB + N + i]), 32'(u));
      check($sformatf("%s_v%0d", tag, i), 32'(out_mem[OB + 2 * N + i]), 32'(v));
    end
  endtask

  // Pulse start, optionally pulse it again at cycle restart_at, and wait (bounded) for done.
  task automatic run_frame(input int restart_at, output int lat, output int first_wr);
    @(negedge clk); bus.start = 1'b1;
    lat = 0;
    first_wr = -1;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == restart_at);
      if (first_wr < 0 && bus.W_en) first_wr = lat;
      if (bus.done) break;
    end
  endtask

  task automatic frame_checks(input string tag, input int restart_at);
    int lat, first_wr;
    clear_out();
    run_frame(restart_at, lat, first_wr);
    check({tag, "_done_lat"}, lat, 7 * N + 1);
    check({tag, "_first_wr"}, first_wr, 5);
    check({tag, "_wr_count"}, wr_count, 3 * N);
    @(negedge clk);
    check({tag, "_busy_drop"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    int lat, gap;
    bus.start   = 1'b0;
    if_hi.start = 1'b0;
    if_lo.start = 1'b0;

    #2;
    check("rst_strobes", {bus.R_en, bus.W_en, bus.busy, bus.done}, 0);
    check("rst_addrs", {bus.R_addr, 14'd0}, 0);
    check("rst_wdata", {bus.W_addr, bus.W_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {bus.busy, bus.done, bus.R_en, bus.W_en}, 0);

    // Directed colour frames.
    load(0); frame_checks("black", -1); verify_const("black", 16'h1010, 16'h8080, 16'h8080);
    load(1); frame_checks("white", -1); verify_const("white", 16'hEBEB, 16'h8080, 16'h8080);
    load(2); frame_checks("lane",  -1); verify_const("lane",  16'h1051, 16'h805A, 16'h80F0);

    // Random frames against the model.
    for (int f = 0; f < 3; f++) begin
      load(3);
      frame_checks($sformatf("rand%0d", f), -1);
      verify_model($sformatf("rand%0d", f));
    end

    // A start pulse mid-frame is ignored.
    load(3); frame_checks("restart", 10); verify_model("restart");

    // Start held high: the next frame follows straight after done.
    load(3); clear_out();
    @(negedge clk); bus.start = 1'b1;
    lat = 0;
    while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
    check("hold_lat1", lat, 7 * N + 1);
    verify_model("hold_f1");
    load(3);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) check("hold_idle_gap", {31'd0, bus.busy}, 0);
      if (gap == 2) bus.start = 1'b0;
    end while (!bus.done && gap < 200);
    check("hold_gap", gap, 7 * N + 2);
    check("hold_wr_count", wr_count, 6 * N);
    verify_model("hold_f2");
    @(negedge clk);

    // Clamp instances.
    @(negedge clk); if_hi.start = 1'b1; if_lo.start = 1'b1;
    @(negedge clk); if_hi.start = 1'b0; if_lo.start = 1'b0;
    lat = 0;
    while (!if_hi.done && lat < 100) begin @(negedge clk); lat++; end
    check("clamp_done", {31'd0, if_hi.done}, 1);
    check("clamp_hi_y", {16'd0, y_hi}, 32'h0000_FFFF);
    check("clamp_lo_y", {16'd0, y_lo}, 32'h0000_0000);
    repeat (2) @(negedge clk);

    // Reset during WR_U of idx 1 aborts the frame.
    load(3); clear_out();
    @(negedge clk); bus.start = 1'b1;
    lat = 0;
    while (lat < 13) begin @(negedge clk); lat++; bus.start = 1'b0; end
    check("pre_rst_wr_u", {13'd0, bus.W_en, bus.W_addr}, {13'd0, 1'b1, 18'(OB + N + 1)});
    #1 rst = 1'b0;
    #1;
    check("abort_strobes", {bus.R_en, bus.W_en, bus.busy, bus.done}, 0);
    check("abort_bus", {bus.W_addr, bus.W_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat = 0;
    gap = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) lat++;
    end
    check("abort_no_activity", lat, 0);
    check("abort_wr_count", wr_count, 4);

    load(3); frame_checks("post_rst", -1); verify_model("post_rst");

    check("no_rd_wr_overlap", overlap_count, 0);
    check("wdata_zero_idle", idle_wdata_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
